// File: rtl/spike_aer_encoder.sv
// rtl/spike_aer_encoder.sv - threshold-crossing spike detector feeding a timestamped AER event FIFO
// Optional SPIKE_ISI_EN stores the inter-spike interval alongside each event.
module spike_aer_encoder #(
  parameter logic [31:0] THRESH = 32'h41F00000,
  parameter int          DEPTH  = 8,
  parameter int          TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     v_valid,
  input  logic [31:0]              vn,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [TS_W-1:0]          ev_isi,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic            above;
  logic            prev_above;
  logic            spike;
  logic [TS_W-1:0] ts;
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            ovf;
  logic [TS_W-1:0] ts_mem [DEPTH];

  // Positive non-NaN floats order the same as their magnitude bit patterns.
  assign above = !vn[31] && ((vn[30:23] != 8'hFF) || (vn[22:0] == 23'd0)) &&
                 (vn[30:0] >= THRESH[30:0]);
  assign spike = v_valid && above && !prev_above;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && ev_ready;
  assign push  = spike && (!full || pop);

  assign ev_valid = !empty;
  assign ev_count = wptr - rptr;
  assign overflow = ovf;
  assign ev_ts    = empty ? '0 : ts_mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      prev_above <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      ovf        <= 1'b0;
    end else begin
      if (v_valid) begin
        ts         <= ts + TS_W'(1);
        prev_above <= above;
      end
      if (push)
        wptr <= wptr + (AW+1)'(1);
      if (pop)
        rptr <= rptr + (AW+1)'(1);
      if (spike && full && !pop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      ts_mem[wptr[AW-1:0]] <= ts;
  end

`ifdef SPIKE_ISI_EN
  logic [TS_W-1:0] last_ts;
  logic            first;
  logic [TS_W-1:0] isi_new;
  logic [TS_W-1:0] isi_mem [DEPTH];

  // Dropped spikes still advance last_ts so the next interval stays physical.
  assign isi_new = first ? '0 : (ts - last_ts);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ts <= '0;
      first   <= 1'b1;
    end else if (spike) begin
      last_ts <= ts;
      first   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      isi_mem[wptr[AW-1:0]] <= isi_new;
  end

  assign ev_isi = empty ? '0 : isi_mem[rptr[AW-1:0]];
`else
  assign ev_isi = '0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb/tb_spike_aer_encoder.sv - scoreboard bench for spike_aer_encoder (default and TS_W=4 instances)
module tb_spike_aer_encoder;

  typedef struct {
    logic [15:0] ts;
    logic [15:0] isi;
  } ev_t;

`ifdef SPIKE_ISI_EN
  localparam bit ISI_EN = 1'b1;
`else
  localparam bit ISI_EN = 1'b0;
`endif

  localparam logic [31:0] NEG65  = 32'hC2820000;
  localparam logic [31:0] NEG30  = 32'hC1F00000;
  localparam logic [31:0] POS30  = 32'h41F00000;
  localparam logic [31:0] POS35  = 32'h420C0000;
  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam logic [31:0] PINF   = 32'h7F800000;
  localparam logic [31:0] NINF   = 32'hFF800000;
  localparam logic [31:0] JUSTLO = 32'h41EFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_valid;
  logic [31:0] vn;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_ts;
  logic [15:0] ev_isi;
  logic [3:0]  ev_count;
  logic        overflow;

  logic        rst4;
  logic        v4_valid;
  logic [31:0] vn4;
  logic        ev4_valid;
  logic        ev4_ready;
  logic [3:0]  ev4_ts;
  logic [3:0]  ev4_isi;
  logic [3:0]  ev4_count;
  logic        overflow4;

  int checks = 0;
  int errors = 0;

  ev_t         sb[$];
  logic [15:0] m_ts = '0;
  logic [15:0] m_last = '0;
  bit          m_first = 1'b1;
  bit          hold_v = 1'b0;
  logic [15:0] hold_ts = '0;

  always #5 clk = ~clk;

  spike_aer_encoder #(.THRESH(32'h41F00000), .DEPTH(8), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .v_valid(v_valid), .vn(vn),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_isi(ev_isi),
    .ev_count(ev_count), .overflow(overflow)
  );

  spike_aer_encoder #(.THRESH(32'h41F00000), .DEPTH(8), .TS_W(4)) dut4 (
    .clk(clk), .rst(rst4), .v_valid(v4_valid), .vn(vn4),
    .ev_valid(ev4_valid), .ev_ready(ev4_ready), .ev_ts(ev4_ts), .ev_isi(ev4_isi),
    .ev_count(ev4_count), .overflow(overflow4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sample(input logic [31:0] v, input bit exp_spike, input bit exp_acc);
    ev_t e;
    v_valid = 1'b1;
    vn = v;
    if (exp_spike) begin
      e.ts  = m_ts;
      e.isi = (!ISI_EN || m_first) ? 16'd0 : (m_ts - m_last);
      m_last = m_ts;
      m_first = 1'b0;
      if (exp_acc) sb.push_back(e);
    end
    @(posedge clk); #1;
    v_valid = 1'b0;
    m_ts = m_ts + 16'd1;
  endtask

  task automatic idle_cycle(input logic [31:0] v);
    vn = v;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !ev_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", ev_valid, 0);
  endtask

  task automatic sample4(input logic [31:0] v);
    v4_valid = 1'b1;
    vn4 = v;
    @(posedge clk); #1;
    v4_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual_ts=%0d expected none", ev_ts);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("ev_ts", ev_ts, e.ts);
          chk("ev_isi", ev_isi, e.isi);
        end
      end else if (!ev_valid) begin
        chk("idle_ts", ev_ts, 0);
        chk("idle_isi", ev_isi, 0);
      end else if (hold_v) begin
        chk("hold_ts", ev_ts, hold_ts);
      end
      hold_v  = ev_valid && !ev_ready;
      hold_ts = ev_ts;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; v_valid = 1'b0; vn = '0; ev_ready = 1'b0;
    rst4 = 1'b1; v4_valid = 1'b0; vn4 = '0; ev4_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rst4 = 1'b0;
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_overflow", overflow, 0);

    // first crossing at sample 3, visible one cycle later
    for (int i = 0; i < 3; i++) sample(NEG65, 0, 0);
    sample(POS30, 1, 1);
    chk("lat_valid", ev_valid, 1);
    chk("lat_count", ev_count, 1);
    chk("lat_ts", ev_ts, 3);
    chk("lat_isi", ev_isi, 0);
    drain();

    // negatives, NaN, just-below, ignored idle input, then a spike at ts=10
    sample(NEG65, 0, 0);
    sample(NEG30, 0, 0);
    sample(QNAN, 0, 0);
    sample(JUSTLO, 0, 0);
    idle_cycle(POS35);
    sample(NEG65, 0, 0);
    sample(NINF, 0, 0);
    sample(POS30, 1, 1);
    sample(POS35, 0, 0);
    sample(NEG65, 0, 0);
    sample(POS35, 1, 1);
    sample(POS35, 0, 0);
    sample(NEG65, 0, 0);
    sample(PINF, 1, 1);
    drain();
    chk("no_overflow", overflow, 0);

    // fill with ev_ready low, ninth spike dropped
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample(NEG65, 0, 0);
      sample(POS30, 1, i < 8);
    end
    chk("full_count", ev_count, 8);
    chk("full_overflow", overflow, 1);
    chk("full_valid", ev_valid, 1);
    sample(NEG65, 0, 0);
    ev_ready = 1'b1;
    sample(POS30, 1, 1);
    ev_ready = 1'b0;
    chk("coinc_count", ev_count, 8);
    drain();
    chk("sticky_overflow", overflow, 1);

    // TS_W=4: wrap to timestamp 0 at sample 16
    for (int i = 0; i < 16; i++) sample4(NEG65);
    sample4(POS30);
    chk("wrap_valid", ev4_valid, 1);
    chk("wrap_ts", ev4_ts, 0);
    chk("wrap_isi", ev4_isi, 0);
    sample4(NEG65); sample4(POS30);
    sample4(NEG65); sample4(POS30);
    chk("q3_count", ev4_count, 3);

    // reset wins over a concurrent sample and pop
    rst4 = 1'b1; v4_valid = 1'b1; vn4 = NEG65; ev4_ready = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0; v4_valid = 1'b0; ev4_ready = 1'b0;
    chk("rst4_valid", ev4_valid, 0);
    chk("rst4_count", ev4_count, 0);
    chk("rst4_overflow", overflow4, 0);
    chk("rst4_ts_out", ev4_ts, 0);
    sample4(POS30);
    chk("post_rst_valid", ev4_valid, 1);
    chk("post_rst_ts", ev4_ts, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
